// File: rtl/lsu_ctrl.sv
// Load/store controller: one LDW/STW in flight over a req/gnt/rvalid data-memory bus.
// Optional misaligned-address rejection when LSU_ALIGN_CHECK_EN is defined.
module lsu_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RD_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_op,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_wdata,
   input  logic [RD_W-1:0]   in_rd,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              wb_valid,
   output logic [RD_W-1:0]   wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              st_done,
   output logic              err
);

   // state  | meaning
   // S_IDLE | ready for a new operation
   // S_REQ  | mem_req held with stable address/data until mem_gnt
   // S_WAIT | granted, waiting for mem_rvalid (read data or write ack)

   localparam logic [5:0] OP_LDW = 6'b001100;
   localparam logic [5:0] OP_STW = 6'b001101;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t          state_q, state_d;
   logic [RD_W-1:0] rd_q;
   logic            accept, is_mem_op, misaligned, start;
   logic            wb_valid_d, st_done_d, err_d;

   assign in_ready  = (state_q == S_IDLE);
   assign mem_req   = (state_q == S_REQ);
   assign accept    = in_valid && in_ready;
   assign is_mem_op = (in_op == OP_LDW) || (in_op == OP_STW);

`ifdef LSU_ALIGN_CHECK_EN
   assign misaligned = (in_addr[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      start      = 1'b0;
      err_d      = 1'b0;
      wb_valid_d = 1'b0;
      st_done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (is_mem_op && !misaligned) begin
                  start   = 1'b1;
                  state_d = S_REQ;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_REQ: begin
            if (mem_gnt) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               state_d = S_IDLE;
               // loads to r0 still complete on the bus but never write back
               if (mem_we)              st_done_d  = 1'b1;
               else if (rd_q != '0)     wb_valid_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rd_q      <= '0;
         wb_valid  <= 1'b0;
         wb_rd     <= '0;
         wb_data   <= '0;
         st_done   <= 1'b0;
         err       <= 1'b0;
      end else begin
         wb_valid <= wb_valid_d;
         st_done  <= st_done_d;
         err      <= err_d;
         if (start) begin
            mem_we    <= (in_op == OP_STW);
            mem_addr  <= in_addr;
            mem_wdata <= in_wdata;
            rd_q      <= in_rd;
         end
         if (wb_valid_d) begin
            wb_rd   <= rd_q;
            wb_data <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: stimulus pushes expected pulses, a forked monitor pops and compares.
// Alignment scenario follows LSU_ALIGN_CHECK_EN as the DUT does.
module tb_lsu_ctrl;

   localparam logic [5:0] OP_LDW = 6'b001100;
   localparam logic [5:0] OP_STW = 6'b001101;
   localparam logic [2:0] K_WB  = 3'b001;
   localparam logic [2:0] K_ST  = 3'b010;
   localparam logic [2:0] K_ERR = 3'b100;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_op;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic [4:0]  in_rd;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        st_done;
   logic        err;

   lsu_ctrl dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .st_done(st_done), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2:0]  kind;
      logic [4:0]  rd;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_pulse(input logic [2:0] kind, input logic [4:0] rd,
                               input logic [31:0] data, input int due);
      exp_t e;
      e.kind = kind; e.rd = rd; e.data = data; e.due = due;
      q.push_back(e);
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic monitor;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && (wb_valid || st_done || err)) begin
            if (q.size() == 0) begin
               check("unexpected_pulse", {err, st_done, wb_valid}, 3'b000);
            end else begin
               e = q.pop_front();
               check("pulse_kind", {err, st_done, wb_valid}, e.kind);
               if (e.due >= 0) check("pulse_cycle", cyc, e.due);
               if (e.kind == K_WB) begin
                  check("wb_rd", wb_rd, e.rd);
                  check("wb_data", wb_data, e.data);
               end
            end
         end
      end
   endtask

   task automatic drive_op(input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd);
      in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wdata; in_rd = rd;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_op = '0; in_addr = '0; in_wdata = '0; in_rd = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      fork
         monitor();
      join_none

      tick; tick;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_outputs", {wb_valid, st_done, err, wb_rd, wb_data}, '0);
      rst = 1'b0;

      // load, immediate grant, response next cycle
      drive_op(OP_LDW, 32'h0000_0010, 32'h0, 5'd5);
      expect_pulse(K_WB, 5'd5, 32'hDEAD_BEEF, cyc + 3);
      tick;
      in_valid = 1'b0;
      check("ld_mem_req", mem_req, 1'b1);
      check("ld_mem_we", mem_we, 1'b0);
      check("ld_mem_addr", mem_addr, 32'h0000_0010);
      check("ld_in_ready_busy", in_ready, 1'b0);
      mem_gnt = 1'b1;
      tick;
      mem_gnt = 1'b0;
      check("ld_req_drop", mem_req, 1'b0);
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick;
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      check("ld_ready_on_pulse", in_ready, 1'b1);

      // store issued back-to-back, grant withheld for 4 cycles
      drive_op(OP_STW, 32'h0000_0020, 32'h1234_5678, 5'd0);
      expect_pulse(K_ST, 5'd0, 32'h0, cyc + 7);
      tick;
      in_valid = 1'b0; in_op = 6'h3f; in_addr = 32'hFFFF_FFFF; in_wdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 5; i++) begin
         check("st_hold", {mem_req, mem_we, mem_addr, mem_wdata},
               {1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678});
         mem_gnt = (i == 4);
         tick;
      end
      mem_gnt = 1'b0;
      check("st_req_drop", mem_req, 1'b0);
      mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      tick;
      mem_rvalid = 1'b0;
      check("st_wb_hold", {wb_rd, wb_data}, {5'd5, 32'hDEAD_BEEF});

      // illegal opcode
      drive_op(6'b000000, 32'h0000_0030, 32'h0, 5'd1);
      expect_pulse(K_ERR, 5'd0, 32'h0, cyc + 1);
      tick;
      in_valid = 1'b0;
      check("ill_no_req", mem_req, 1'b0);
      check("ill_in_ready", in_ready, 1'b1);
      tick;
      check("ill_still_idle", {mem_req, in_ready}, 2'b01);

      // load to r0: bus activity, no writeback
      drive_op(OP_LDW, 32'h0000_0040, 32'h0, 5'd0);
      tick;
      in_valid = 1'b0;
      check("r0_mem_req", mem_req, 1'b1);
      mem_gnt = 1'b1;
      tick;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
      tick;
      mem_rvalid = 1'b0;
      check("r0_no_wb", {wb_valid, err}, 2'b00);
      check("r0_wb_hold", {wb_rd, wb_data}, {5'd5, 32'hDEAD_BEEF});
      check("r0_in_ready", in_ready, 1'b1);

      // spurious gnt/rvalid while idle
      mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hAAAA_AAAA;
      tick; tick;
      mem_rvalid = 1'b0; mem_gnt = 1'b0;
      check("spur_idle", {mem_req, in_ready, wb_valid, st_done, err}, 5'b01000);
      check("spur_wb_hold", wb_data, 32'hDEAD_BEEF);
      check("spur_addr_hold", mem_addr, 32'h0000_0040);

      // reset while waiting for the response
      drive_op(OP_LDW, 32'h0000_0050, 32'h0, 5'd7);
      tick;
      in_valid = 1'b0;
      mem_gnt = 1'b1;
      tick;
      mem_gnt = 1'b0;
      rst = 1'b1;
      tick;
      check("rstmid_req", mem_req, 1'b0);
      check("rstmid_ready", in_ready, 1'b1);
      check("rstmid_no_wb", wb_valid, 1'b0);
      rst = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
      tick;
      mem_rvalid = 1'b0;
      check("rstmid_late_rvalid", {wb_valid, mem_req}, 2'b00);

      drive_op(OP_LDW, 32'h0000_0060, 32'h0, 5'd9);
      expect_pulse(K_WB, 5'd9, 32'hCAFE_F00D, cyc + 3);
      tick;
      in_valid = 1'b0;
      check("post_rst_addr", mem_addr, 32'h0000_0060);
      mem_gnt = 1'b1;
      tick;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      tick;
      mem_rvalid = 1'b0;

      // misaligned load
      drive_op(OP_LDW, 32'h0000_0012, 32'h0, 5'd3);
`ifdef LSU_ALIGN_CHECK_EN
      expect_pulse(K_ERR, 5'd0, 32'h0, cyc + 1);
      tick;
      in_valid = 1'b0;
      check("align_no_req", mem_req, 1'b0);
      check("align_in_ready", in_ready, 1'b1);
      tick;
      check("align_still_idle", mem_req, 1'b0);
`else
      expect_pulse(K_WB, 5'd3, 32'h0BAD_CAFE, cyc + 3);
      tick;
      in_valid = 1'b0;
      check("align_pass_addr", {mem_req, mem_addr}, {1'b1, 32'h0000_0012});
      mem_gnt = 1'b1;
      tick;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_CAFE;
      tick;
      mem_rvalid = 1'b0;
`endif

      tick; tick;
      check("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
